// File: rtl/ppu_obj_pkg.sv
// Shared object-pipeline definitions: OAM scan constants, the sprite store
// record and the mode-2 scan sequencer states.
package ppu_obj_pkg;

    localparam int OAM_ENTRIES = 40;
    localparam int MAX_SPRITES = 10;
    localparam int Y_OFFSET    = 16;

    typedef struct packed {
        logic [5:0] idx;
        logic [3:0] line;
        logic [7:0] x;
    } obj_store_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        CMP,
        DONE
    } scan_state_t;

endpackage

// File: rtl/sprite_y_match.sv
// Vertical sprite hit test: is the current line inside this sprite's rows,
// and which row of the sprite does it fall on.
module sprite_y_match
    import ppu_obj_pkg::*;
(
    input  logic [7:0] ly,
    input  logic [7:0] oam_y,
    input  logic       obj_size,
    output logic       hit,
    output logic [3:0] line
);

    logic [8:0] d;
    logic [8:0] height;

    // Ninth bit keeps ly=255 / oam_y=0 (d=271) distinct from a small positive row.
    assign d      = {1'b0, ly} + 9'(Y_OFFSET) - {1'b0, oam_y};
    assign height = obj_size ? 9'd16 : 9'd8;
    assign hit    = !d[8] && (d < height);
    assign line   = d[3:0];

endmodule

// File: rtl/oam_scan_writer.sv
// Mode-2 OAM scan sequencer: walks all 40 OAM entries once per line and
// writes the first ten Y-hits into the sprite store.
module oam_scan_writer
    import ppu_obj_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_start,
    input  logic [7:0] ly,
    input  logic       obj_size,
    output logic [5:0] oam_index,
    output logic       oam_rd,
    input  logic [7:0] oam_y,
    input  logic [7:0] oam_x,
    output logic       store_wr,
    output logic [3:0] store_slot,
    output logic [5:0] store_idx,
    output logic [3:0] store_line,
    output logic [7:0] store_x,
    output logic [3:0] sprite_count,
    output logic       scan_busy,
    output logic       scan_done
);

    scan_state_t      state, state_next;
    logic [7:0]       ly_l;
    logic             obj_size_l;
    logic [5:0]       entry_cnt;
    logic             last_entry;
    logic             hit;
    logic [3:0]       match_line;
    obj_store_entry_t store_q;

    sprite_y_match u_y_match (
        .ly       (ly_l),
        .oam_y    (oam_y),
        .obj_size (obj_size_l),
        .hit      (hit),
        .line     (match_line)
    );

    assign last_entry = (entry_cnt == 6'(OAM_ENTRIES - 1));

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (scan_start) state_next = ADDR;
            ADDR: state_next = scan_start ? ADDR : CMP;
            CMP: begin
                if (scan_start)      state_next = ADDR;
                else if (last_entry) state_next = DONE;
                else                 state_next = ADDR;
            end
            DONE: state_next = scan_start ? ADDR : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        oam_rd    = (state == ADDR);
        oam_index = oam_rd ? entry_cnt : 6'd0;
        scan_busy = (state == ADDR) || (state == CMP);
        scan_done = (state == DONE);
    end

    // A restart during CMP takes priority, which drops that entry's strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            ly_l         <= '0;
            obj_size_l   <= 1'b0;
            entry_cnt    <= '0;
            sprite_count <= '0;
            store_wr     <= 1'b0;
            store_slot   <= '0;
            store_q      <= '0;
        end else begin
            store_wr <= 1'b0;
            if (scan_start) begin
                ly_l         <= ly;
                obj_size_l   <= obj_size;
                entry_cnt    <= '0;
                sprite_count <= '0;
            end else if (state == CMP) begin
                if (!last_entry) entry_cnt <= entry_cnt + 6'd1;
                if (hit && (sprite_count < 4'(MAX_SPRITES))) begin
                    store_wr     <= 1'b1;
                    store_slot   <= sprite_count;
                    store_q      <= '{idx: entry_cnt, line: match_line, x: oam_x};
                    sprite_count <= sprite_count + 4'd1;
                end
            end
        end
    end

    assign store_idx  = store_q.idx;
    assign store_line = store_q.line;
    assign store_x    = store_q.x;

endmodule

// File: tb/tb_oam_scan_writer.sv
// Directed bench for oam_scan_writer: table of full-line scans plus
// hand-written restart and mid-scan reset sequences.
module tb_oam_scan_writer;

    logic       clk = 1'b0;
    logic       reset, scan_start, obj_size;
    logic [7:0] ly, oam_y, oam_x;
    logic [5:0] oam_index, store_idx;
    logic       oam_rd, store_wr, scan_busy, scan_done;
    logic [3:0] store_slot, store_line, sprite_count;
    logic [7:0] store_x;

    always #5 clk = ~clk;

    oam_scan_writer dut (
        .clk          (clk),
        .reset        (reset),
        .scan_start   (scan_start),
        .ly           (ly),
        .obj_size     (obj_size),
        .oam_index    (oam_index),
        .oam_rd       (oam_rd),
        .oam_y        (oam_y),
        .oam_x        (oam_x),
        .store_wr     (store_wr),
        .store_slot   (store_slot),
        .store_idx    (store_idx),
        .store_line   (store_line),
        .store_x      (store_x),
        .sprite_count (sprite_count),
        .scan_busy    (scan_busy),
        .scan_done    (scan_done)
    );

    // OAM model: data for the requested entry appears the cycle after oam_rd.
    logic [7:0] y_mem [40];
    logic [7:0] x_mem [40];
    logic [5:0] rd_idx = '0;
    always @(posedge clk) if (oam_rd) rd_idx <= oam_index;
    assign oam_y = (rd_idx < 6'd40) ? y_mem[rd_idx] : 8'h00;
    assign oam_x = (rd_idx < 6'd40) ? x_mem[rd_idx] : 8'h00;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0] ly;
        logic       os;
        logic [7:0] fill_y, fill_x;
        int         a_idx;
        logic [7:0] a_y, a_x;
        int         b_idx;
        logic [7:0] b_y, b_x;
        int         exp_cnt;
        int         first_cyc, first_idx, first_line;
        logic [7:0] first_x;
        int         last_idx, last_cyc;
        logic [7:0] last_x;
    } vec_t;

    vec_t vecs [8];

    int         n_wr, done_cyc, busy_n;
    bit         rd_ok, seq_ok;
    logic [3:0] end_count;
    int         wr_cyc  [16];
    logic [5:0] wr_idx  [16];
    logic [3:0] wr_line [16];
    logic [7:0] wr_x    [16];

    task automatic load_oam(input vec_t v);
        for (int e = 0; e < 40; e++) begin
            y_mem[e] = v.fill_y;
            x_mem[e] = v.fill_x;
        end
        if (v.a_idx < 40) begin y_mem[v.a_idx] = v.a_y; x_mem[v.a_idx] = v.a_x; end
        if (v.b_idx < 40) begin y_mem[v.b_idx] = v.b_y; x_mem[v.b_idx] = v.b_x; end
    endtask

    // Called at a negedge; returns at the negedge of scan cycle 1.
    task automatic pulse(input logic [7:0] lyv, input logic osv);
        scan_start = 1'b1;
        ly         = lyv;
        obj_size   = osv;
        @(negedge clk);
        scan_start = 1'b0;
    endtask

    // Samples one scan from cycle 1 until scan_done (bounded), scrambling
    // ly/obj_size mid-scan; returns at the negedge after scan_done.
    task automatic monitor(input logic [7:0] lyv, input logic osv);
        n_wr = 0; done_cyc = 0; busy_n = 0; rd_ok = 1; seq_ok = 1; end_count = 4'hF;
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin ly = ~lyv; obj_size = ~osv; end
            if (scan_busy) busy_n++;
            if (oam_rd !== ((c % 2 == 1) && (c <= 79))) rd_ok = 0;
            if (oam_rd && (oam_index !== 6'((c - 1) / 2))) rd_ok = 0;
            if (store_wr) begin
                if (n_wr < 16) begin
                    wr_cyc[n_wr]  = c;
                    wr_idx[n_wr]  = store_idx;
                    wr_line[n_wr] = store_line;
                    wr_x[n_wr]    = store_x;
                end
                if (store_slot !== 4'(n_wr)) seq_ok = 0;
                n_wr++;
            end
            if (scan_done) begin
                done_cyc  = c;
                end_count = sprite_count;
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{8'd0,   1'b0, 8'd0,  8'd0,    0, 8'd16,  8'd8,    63, 8'd0,   8'd0,    1,  3,  0,  0, 8'd8,     0, 3,  8'd8};
        vecs[1] = '{8'd0,   1'b0, 8'd0,  8'd0,    5, 8'd8,   8'h33,   63, 8'd0,   8'd0,    0,  0,  0,  0, 8'd0,     0, 0,  8'd0};
        vecs[2] = '{8'd0,   1'b1, 8'd0,  8'd0,    5, 8'd8,   8'h33,   63, 8'd0,   8'd0,    1,  13, 5,  8, 8'h33,    5, 13, 8'h33};
        vecs[3] = '{8'd20,  1'b0, 8'd30, 8'h50,   63, 8'd0,  8'd0,    63, 8'd0,   8'd0,    10, 3,  0,  6, 8'h50,    9, 21, 8'h50};
        vecs[4] = '{8'd255, 1'b1, 8'd0,  8'd0,    39, 8'd0,  8'd0,    38, 8'd255, 8'h77,   0,  0,  0,  0, 8'd0,     0, 0,  8'd0};
        vecs[5] = '{8'd254, 1'b1, 8'd0,  8'd0,    39, 8'd0,  8'd0,    38, 8'd255, 8'h77,   1,  79, 38, 15, 8'h77,   38, 79, 8'h77};
        vecs[6] = '{8'd10,  1'b0, 8'd0,  8'd0,    3, 8'd19,  8'h11,   7,  8'd34,  8'h22,   1,  9,  3,  7, 8'h11,    3, 9,  8'h11};
        vecs[7] = '{8'd0,   1'b0, 8'd0,  8'd0,    39, 8'd16, 8'hA5,   63, 8'd0,   8'd0,    1,  81, 39, 0, 8'hA5,    39, 81, 8'hA5};

        reset = 1'b1; scan_start = 1'b0; ly = 8'd0; obj_size = 1'b0;
        for (int e = 0; e < 40; e++) begin y_mem[e] = 8'd0; x_mem[e] = 8'd0; end
        repeat (3) @(negedge clk);
        check("reset_outputs", {oam_index, oam_rd, store_wr, store_slot, store_idx, store_line,
                                store_x, sprite_count, scan_busy, scan_done}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_outputs", {oam_rd, store_wr, sprite_count, scan_busy, scan_done}, 64'd0);

        for (int i = 0; i < 8; i++) begin
            load_oam(vecs[i]);
            pulse(vecs[i].ly, vecs[i].os);
            monitor(vecs[i].ly, vecs[i].os);
            check($sformatf("v%0d_writes", i), n_wr, vecs[i].exp_cnt);
            check($sformatf("v%0d_sprite_count", i), end_count, vecs[i].exp_cnt);
            check($sformatf("v%0d_done_cycle", i), done_cyc, 81);
            check($sformatf("v%0d_busy_cycles", i), busy_n, 80);
            check($sformatf("v%0d_rd_sequence", i), rd_ok, 1);
            check($sformatf("v%0d_slot_sequence", i), seq_ok, 1);
            check($sformatf("v%0d_idle_after", i), {scan_busy, scan_done}, 0);
            if (vecs[i].exp_cnt > 0 && n_wr > 0) begin
                int l;
                l = (n_wr > 16 ? 16 : n_wr) - 1;
                check($sformatf("v%0d_first_cycle", i), wr_cyc[0], vecs[i].first_cyc);
                check($sformatf("v%0d_first_idx", i), wr_idx[0], vecs[i].first_idx);
                check($sformatf("v%0d_first_line", i), wr_line[0], vecs[i].first_line);
                check($sformatf("v%0d_first_x", i), wr_x[0], vecs[i].first_x);
                check($sformatf("v%0d_last_idx", i), wr_idx[l], vecs[i].last_idx);
                check($sformatf("v%0d_last_cycle", i), wr_cyc[l], vecs[i].last_cyc);
                check($sformatf("v%0d_hold_x", i), store_x, vecs[i].last_x);
            end
        end

        // Restart at cycle 30, during the CMP of a hitting entry 14.
        begin
            int pre_wr, pre_done;
            for (int e = 0; e < 40; e++) begin y_mem[e] = 8'd0; x_mem[e] = 8'd0; end
            y_mem[0] = 8'd30;  x_mem[0] = 8'h41;
            y_mem[14] = 8'd30; x_mem[14] = 8'h42;
            pre_wr = 0; pre_done = 0;
            pulse(8'd20, 1'b0);
            for (int c = 1; c < 30; c++) begin
                if (store_wr) pre_wr++;
                if (scan_done) pre_done++;
                @(negedge clk);
            end
            check("restart_pre_writes", pre_wr, 1);
            check("restart_pre_busy", scan_busy, 1);
            pulse(8'd25, 1'b1);
            check("restart_strobe_dropped", store_wr, 0);
            check("restart_count_cleared", sprite_count, 0);
            check("restart_first_addr", {oam_rd, oam_index}, {1'b1, 6'd0});
            monitor(8'd25, 1'b1);
            check("restart_no_early_done", pre_done, 0);
            check("restart_done_cycle", done_cyc, 81);
            check("restart_writes", n_wr, 2);
            check("restart_rd_sequence", rd_ok, 1);
            check("restart_w0", {wr_idx[0], wr_line[0], wr_x[0]}, {6'd0, 4'd11, 8'h41});
            check("restart_w1", {wr_idx[1], wr_line[1], wr_x[1]}, {6'd14, 4'd11, 8'h42});
            check("restart_w1_cycle", wr_cyc[1], 31);
            check("restart_sprite_count", end_count, 2);
        end

        // Reset at cycle 40, the CMP of hitting entry 19.
        begin
            int bad;
            for (int e = 0; e < 40; e++) begin y_mem[e] = 8'd0; x_mem[e] = 8'd0; end
            y_mem[19] = 8'd16; x_mem[19] = 8'h99;
            pulse(8'd0, 1'b0);
            for (int c = 1; c < 40; c++) @(negedge clk);
            check("reset_pre_busy", scan_busy, 1);
            reset = 1'b1;
            @(negedge clk);
            check("reset_mid_outputs", {oam_index, oam_rd, store_wr, store_slot, store_idx, store_line,
                                        store_x, sprite_count, scan_busy, scan_done}, 64'd0);
            reset = 1'b0;
            bad = 0;
            repeat (90) begin
                @(negedge clk);
                if (store_wr || scan_done || scan_busy) bad++;
            end
            check("reset_quiet_after", bad, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
